timer_update_ctrl: RTL and testbench

Control/sequencing unit for the general-purpose timer counter datapath. Owns the prescaler, the ARR preload/shadow pair and update-event (UEV) generation, and produces the counter's advance enable and synchronous clear. Also maintains the update interrupt flag (UIF) and optional one-pulse mode. Sits between the timer register file and the auto-reload counter.

---
 rtl/timer_update_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_timer_update_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_update_ctrl.sv
// Prescaler, ARR preload/shadow pair and update-event sequencing for the timer counter.
// Define TIM_OPM_EN to build in one-pulse mode (otherwise opm_i is ignored, cen_clr_o tied low).
module timer_update_ctrl #(
  parameter int WIDTH     = 16,
  parameter int PSC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen_i,
  input  logic                 arpe_i,
  input  logic                 udis_i,
  input  logic                 opm_i,
  input  logic                 ug_i,
  input  logic                 arr_wr_i,
  input  logic [WIDTH-1:0]     arr_wdata_i,
  input  logic                 psc_wr_i,
  input  logic [PSC_WIDTH-1:0] psc_wdata_i,
  input  logic                 uif_clr_i,
  input  logic [WIDTH-1:0]     count_i,
  output logic                 cnt_tick_o,
  output logic                 cnt_clr_o,
  output logic [WIDTH-1:0]     arr_o,
  output logic                 uev_o,
  output logic                 uif_o,
  output logic                 running_o,
  output logic                 cen_clr_o
);

  logic [PSC_WIDTH-1:0] psc_cnt;
  logic [PSC_WIDTH-1:0] psc_active;
  logic [PSC_WIDTH-1:0] psc_preload;
  logic [WIDTH-1:0]     arr_preload;
  logic [WIDTH-1:0]     arr_shadow;
  logic                 uif;
  logic                 uev_q;
  logic                 cnt_clr_q;
  logic                 opm_stop;

  logic                 running;
  logic                 psc_wrap;
  logic                 tick;
  logic                 overflow;
  logic                 overflow_uev;
  logic                 uev;

  logic [PSC_WIDTH-1:0] psc_cnt_next;
  logic [PSC_WIDTH-1:0] psc_active_next;
  logic [PSC_WIDTH-1:0] psc_preload_next;
  logic [WIDTH-1:0]     arr_preload_next;
  logic [WIDTH-1:0]     arr_shadow_next;
  logic                 uif_next;

  assign running      = cen_i & ~opm_stop;
  assign psc_wrap     = (psc_cnt == psc_active);
  assign tick         = running & psc_wrap;
  assign overflow     = tick & (count_i >= arr_shadow);
  assign overflow_uev = overflow & ~udis_i;
  assign uev          = overflow_uev | ug_i;

  // Prescaler: software update restarts the period even when stopped.
  always_comb begin
    psc_cnt_next = psc_cnt;
    if (ug_i) begin
      psc_cnt_next = '0;
    end else if (running) begin
      if (psc_wrap) begin
        psc_cnt_next = '0;
      end else begin
        psc_cnt_next = psc_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    psc_preload_next = psc_preload;
    psc_active_next  = psc_active;
    if (psc_wr_i) begin
      psc_preload_next = psc_wdata_i;
    end
    if (uev) begin
      psc_active_next = psc_wr_i ? psc_wdata_i : psc_preload;
    end
  end

  // A direct (non-preloaded) write always beats a concurrent update transfer.
  always_comb begin
    arr_preload_next = arr_preload;
    arr_shadow_next  = arr_shadow;
    if (arr_wr_i) begin
      arr_preload_next = arr_wdata_i;
    end
    if (arr_wr_i && !arpe_i) begin
      arr_shadow_next = arr_wdata_i;
    end else if (uev && arpe_i) begin
      arr_shadow_next = arr_wr_i ? arr_wdata_i : arr_preload;
    end
  end

  always_comb begin
    uif_next = uif;
    if (uev) begin
      uif_next = 1'b1;
    end else if (uif_clr_i) begin
      uif_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt     <= '0;
      psc_active  <= '0;
      psc_preload <= '0;
    end else begin
      psc_cnt     <= psc_cnt_next;
      psc_active  <= psc_active_next;
      psc_preload <= psc_preload_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_preload <= {WIDTH{1'b1}};
      arr_shadow  <= {WIDTH{1'b1}};
      uif         <= 1'b0;
    end else begin
      arr_preload <= arr_preload_next;
      arr_shadow  <= arr_shadow_next;
      uif         <= uif_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uev_q     <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      uev_q     <= uev;
      cnt_clr_q <= ug_i;
    end
  end

`ifdef TIM_OPM_EN
  typedef enum logic {
    OPM_ARMED   = 1'b0,
    OPM_STOPPED = 1'b1
  } opm_state_t;

  opm_state_t opm_state;
  opm_state_t opm_state_next;
  logic       opm_fire;
  logic       cen_clr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opm_state <= OPM_ARMED;
      cen_clr_q <= 1'b0;
    end else begin
      opm_state <= opm_state_next;
      cen_clr_q <= opm_fire;
    end
  end

  // Only a genuine counter overflow ends the pulse; software updates never do.
  always_comb begin
    opm_state_next = opm_state;
    opm_fire       = 1'b0;
    case (opm_state)
      OPM_ARMED: begin
        if (overflow_uev && opm_i) begin
          opm_state_next = OPM_STOPPED;
          opm_fire       = 1'b1;
        end
      end
      OPM_STOPPED: begin
        if (!cen_i) begin
          opm_state_next = OPM_ARMED;
        end
      end
      default: begin
        opm_state_next = OPM_ARMED;
      end
    endcase
  end

  assign opm_stop  = (opm_state == OPM_STOPPED);
  assign cen_clr_o = cen_clr_q;
`else
  logic opm_unused;

  assign opm_unused = opm_i;
  assign opm_stop   = 1'b0;
  assign cen_clr_o  = 1'b0;
`endif

  assign cnt_tick_o = tick;
  assign cnt_clr_o  = cnt_clr_q;
  assign arr_o      = arr_shadow;
  assign uev_o      = uev_q;
  assign uif_o      = uif;
  assign running_o  = running;

endmodule

// File: tb/tb_timer_update_ctrl.sv
// Directed self-checking bench for timer_update_ctrl, with a small behavioural
// auto-reload counter standing in for the datapath.
module tb_timer_update_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cen_i;
  logic        arpe_i;
  logic        udis_i;
  logic        opm_i;
  logic        ug_i;
  logic        arr_wr_i;
  logic [15:0] arr_wdata_i;
  logic        psc_wr_i;
  logic [15:0] psc_wdata_i;
  logic        uif_clr_i;
  logic [15:0] count_i;
  logic        cnt_tick_o;
  logic        cnt_clr_o;
  logic [15:0] arr_o;
  logic        uev_o;
  logic        uif_o;
  logic        running_o;
  logic        cen_clr_o;

  int checks;
  int errors;
  int ticks;
  int uevs;
  int first_uev;
  int pattern_err;
  int hold_err;
  int uif_seen;
  int wraps;
  int clrs;

`ifdef TIM_OPM_EN
  localparam bit OPM = 1'b1;
`else
  localparam bit OPM = 1'b0;
`endif

  timer_update_ctrl #(.WIDTH(16), .PSC_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen_i       (cen_i),
    .arpe_i      (arpe_i),
    .udis_i      (udis_i),
    .opm_i       (opm_i),
    .ug_i        (ug_i),
    .arr_wr_i    (arr_wr_i),
    .arr_wdata_i (arr_wdata_i),
    .psc_wr_i    (psc_wr_i),
    .psc_wdata_i (psc_wdata_i),
    .uif_clr_i   (uif_clr_i),
    .count_i     (count_i),
    .cnt_tick_o  (cnt_tick_o),
    .cnt_clr_o   (cnt_clr_o),
    .arr_o       (arr_o),
    .uev_o       (uev_o),
    .uif_o       (uif_o),
    .running_o   (running_o),
    .cen_clr_o   (cen_clr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in auto-reload up-counter driven by the controller's tick/clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_i <= '0;
    end else if (cnt_clr_o) begin
      count_i <= '0;
    end else if (cnt_tick_o) begin
      count_i <= (count_i >= arr_o) ? 16'd0 : count_i + 16'd1;
    end
  end

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    cen_i = 1'b0;
    arpe_i = 1'b0;
    udis_i = 1'b0;
    opm_i = 1'b0;
    ug_i = 1'b0;
    arr_wr_i = 1'b0;
    arr_wdata_i = '0;
    psc_wr_i = 1'b0;
    psc_wdata_i = '0;
    uif_clr_i = 1'b0;

    $display("[TB] reset state");
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_arr", arr_o, 32'hFFFF);
    checkOutput("rst_uif", uif_o, 0);
    checkOutput("rst_uev", uev_o, 0);
    checkOutput("rst_cnt_clr", cnt_clr_o, 0);
    checkOutput("rst_cen_clr", cen_clr_o, 0);
    checkOutput("rst_running", running_o, 0);
    checkOutput("rst_tick", cnt_tick_o, 0);
    applyStimulus(2);
    rst_n = 1'b1;

    $display("[TB] prescale 2, arr 4");
    applyStimulus(1);
    psc_wr_i = 1'b1; psc_wdata_i = 16'd2;
    arr_wr_i = 1'b1; arr_wdata_i = 16'd4;
    applyStimulus(1);
    psc_wr_i = 1'b0; arr_wr_i = 1'b0; ug_i = 1'b1;
    #1;
    checkOutput("arr_direct_write", arr_o, 4);
    applyStimulus(1);
    ug_i = 1'b0;
    #1;
    checkOutput("ug_uev", uev_o, 1);
    checkOutput("ug_cnt_clr", cnt_clr_o, 1);
    checkOutput("ug_uif", uif_o, 1);
    applyStimulus(1);
    uif_clr_i = 1'b1;
    #1;
    checkOutput("uev_single_pulse", uev_o, 0);
    applyStimulus(1);
    uif_clr_i = 1'b0; cen_i = 1'b1;
    #1;
    checkOutput("uif_cleared", uif_o, 0);
    ticks = 0; uevs = 0; first_uev = -1; pattern_err = 0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) begin
        applyStimulus(1);
        #1;
      end
      if (cnt_tick_o) ticks++;
      if (cnt_tick_o !== ((k % 3) == 2)) pattern_err++;
      if (uev_o) begin
        uevs++;
        if (first_uev < 0) first_uev = k;
      end
    end
    checkOutput("psc_tick_count", ticks, 10);
    checkOutput("psc_tick_pattern_errs", pattern_err, 0);
    checkOutput("psc_uev_count", uevs, 1);
    checkOutput("psc_first_uev_cycle", first_uev, 15);
    applyStimulus(1);
    #1;
    checkOutput("psc_second_uev", uev_o, 1);
    checkOutput("psc_uif_set", uif_o, 1);
    cen_i = 1'b0;

    $display("[TB] ARR preload");
    applyStimulus(1);
    arpe_i = 1'b1;
    arr_wr_i = 1'b1; arr_wdata_i = 16'd9;
    psc_wr_i = 1'b1; psc_wdata_i = 16'd0;
    ug_i = 1'b1;
    applyStimulus(1);
    arr_wr_i = 1'b0; psc_wr_i = 1'b0; ug_i = 1'b0; uif_clr_i = 1'b1;
    #1;
    checkOutput("arr_write_through", arr_o, 9);
    applyStimulus(1);
    uif_clr_i = 1'b0; cen_i = 1'b1;
    hold_err = 0;
    for (int j = 0; j < 13; j++) begin
      if (j > 0) applyStimulus(1);
      case (j)
        4:  begin arr_wr_i = 1'b1; arr_wdata_i = 16'd3; end
        5:  arr_wr_i = 1'b0;
        11: begin arpe_i = 1'b0; arr_wr_i = 1'b1; arr_wdata_i = 16'd5; end
        12: begin arr_wr_i = 1'b0; cen_i = 1'b0; end
        default: ;
      endcase
      #1;
      if (j >= 5 && j <= 9 && arr_o !== 16'd9) hold_err++;
      if (j == 10) begin
        checkOutput("preload_transfer_arr", arr_o, 3);
        checkOutput("preload_transfer_uev", uev_o, 1);
        checkOutput("preload_transfer_uif", uif_o, 1);
      end
      if (j == 12) checkOutput("arpe0_direct_arr", arr_o, 5);
    end
    checkOutput("preload_hold_errs", hold_err, 0);

    $display("[TB] update disable");
    applyStimulus(1);
    arpe_i = 1'b1; udis_i = 1'b1;
    arr_wr_i = 1'b1; arr_wdata_i = 16'd7;
    uif_clr_i = 1'b1;
    applyStimulus(1);
    arr_wr_i = 1'b0; uif_clr_i = 1'b0; cen_i = 1'b1;
    uevs = 0; uif_seen = 0; wraps = 0;
    for (int m = 0; m < 14; m++) begin
      if (m > 0) applyStimulus(1);
      #1;
      if (uev_o) uevs++;
      if (uif_o) uif_seen++;
      if (cnt_tick_o && count_i >= arr_o) wraps++;
    end
    checkOutput("udis_uev_count", uevs, 0);
    checkOutput("udis_uif_seen", uif_seen, 0);
    checkOutput("udis_wrapped_twice", (wraps >= 2), 1);
    checkOutput("udis_arr_held", arr_o, 5);
    applyStimulus(1);
    cen_i = 1'b0; ug_i = 1'b1;
    applyStimulus(1);
    ug_i = 1'b0; udis_i = 1'b0;
    #1;
    checkOutput("udis_ug_uev", uev_o, 1);
    checkOutput("udis_ug_cnt_clr", cnt_clr_o, 1);
    checkOutput("udis_ug_arr", arr_o, 7);
    checkOutput("udis_ug_uif", uif_o, 1);

    $display("[TB] ug coincident with overflow and uif clear");
    applyStimulus(1);
    cen_i = 1'b1; uif_clr_i = 1'b1;
    applyStimulus(1);
    uif_clr_i = 1'b0;
    applyStimulus(5);
    #1;
    checkOutput("coinc_uif_pre", uif_o, 0);
    applyStimulus(1);
    ug_i = 1'b1; uif_clr_i = 1'b1;
    #1;
    checkOutput("coinc_overflow_tick", cnt_tick_o, 1);
    applyStimulus(1);
    ug_i = 1'b0; uif_clr_i = 1'b0;
    #1;
    checkOutput("coinc_uev", uev_o, 1);
    checkOutput("coinc_cnt_clr", cnt_clr_o, 1);
    checkOutput("coinc_uif", uif_o, 1);
    applyStimulus(1);
    cen_i = 1'b0;
    #1;
    checkOutput("coinc_uev_single", uev_o, 0);
    checkOutput("coinc_cnt_clr_single", cnt_clr_o, 0);

    $display("[TB] one-pulse mode");
    applyStimulus(1);
    arpe_i = 1'b0; arr_wr_i = 1'b1; arr_wdata_i = 16'd3;
    opm_i = 1'b1; ug_i = 1'b1;
    applyStimulus(1);
    arr_wr_i = 1'b0; ug_i = 1'b0;
    #1;
    checkOutput("opm_arr", arr_o, 3);
    applyStimulus(1);
    cen_i = 1'b1;
    ticks = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) applyStimulus(1);
      #1;
      if (cnt_tick_o) ticks++;
    end
    checkOutput("opm_ticks_before", ticks, 4);
    applyStimulus(1);
    #1;
    checkOutput("opm_uev", uev_o, 1);
    checkOutput("opm_cen_clr", cen_clr_o, OPM ? 1 : 0);
    checkOutput("opm_tick_after", cnt_tick_o, OPM ? 0 : 1);
    checkOutput("opm_running_after", running_o, OPM ? 0 : 1);
    ticks = 0; clrs = 0;
    for (int k = 5; k < 10; k++) begin
      applyStimulus(1);
      #1;
      if (cnt_tick_o) ticks++;
      if (cen_clr_o) clrs++;
    end
    checkOutput("opm_ticks_stopped", ticks, OPM ? 0 : 5);
    checkOutput("opm_cen_clr_single", clrs, 0);
    applyStimulus(1);
    cen_i = 1'b0;
    applyStimulus(1);
    cen_i = 1'b1;
    #1;
    checkOutput("opm_restart_tick", cnt_tick_o, 1);
    checkOutput("opm_restart_running", running_o, 1);

    $display("[TB] reset mid-period");
    applyStimulus(1);
    opm_i = 1'b0; ug_i = 1'b1;
    applyStimulus(1);
    ug_i = 1'b0;
    #2;
    rst_n = 1'b0; cen_i = 1'b0;
    #1;
    checkOutput("midrst_arr", arr_o, 32'hFFFF);
    checkOutput("midrst_uev", uev_o, 0);
    checkOutput("midrst_cnt_clr", cnt_clr_o, 0);
    checkOutput("midrst_cen_clr", cen_clr_o, 0);
    checkOutput("midrst_uif", uif_o, 0);
    checkOutput("midrst_running", running_o, 0);
    checkOutput("midrst_tick", cnt_tick_o, 0);
    applyStimulus(1);
    rst_n = 1'b1; cen_i = 1'b1;
    uevs = 0; clrs = 0; uif_seen = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1);
      #1;
      if (uev_o) uevs++;
      if (cnt_clr_o || cen_clr_o) clrs++;
      if (uif_o) uif_seen++;
    end
    checkOutput("postrst_uev_count", uevs, 0);
    checkOutput("postrst_clr_count", clrs, 0);
    checkOutput("postrst_uif_seen", uif_seen, 0);
    checkOutput("postrst_running", running_o, 1);
    checkOutput("postrst_arr", arr_o, 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
